// File: rtl/branch_sequencer.sv
// Hardwired fetch + conditional-branch control sequencer for the Mini SRC datapath.
// One instruction per accepted start; every strobe is a register loaded with the next state.
module branch_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         MEM_WAIT   = 1,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [4:0] OP_BR      = 5'b10010,
  parameter logic [4:0] SEL_REG    = 5'b00001,
  parameter logic [4:0] SEL_ZLO    = 5'b10011,
  parameter logic [4:0] SEL_PC     = 5'b10100,
  parameter logic [4:0] SEL_MDR    = 5'b10101
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic                  con_ff,
  output logic                  incPC,
  output logic                  e_PC,
  output logic                  e_IR,
  output logic                  e_Y,
  output logic                  e_Z,
  output logic                  e_MAR,
  output logic                  e_MDR,
  output logic                  ram_read,
  output logic                  MDR_read,
  output logic                  Gra,
  output logic                  e_Rout,
  output logic                  e_RA,
  output logic                  e_CON_FF,
  output logic                  imm_sel,
  output logic [3:0]            ALU_op,
  output logic [4:0]            BusDataSelect,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  taken_cnt,
  output logic [CNT_WIDTH-1:0]  nottaken_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_RD, S_MDR, S_IR, S_DEC, S_CON, S_PCY, S_ADD, S_WB, S_DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);
  localparam logic [3:0] ALU_ADD   = 4'b0011;

  state_t               r_state;
  logic [3:0]           r_wait;
  logic [13:0]          r_str;
  logic [3:0]           r_alu;
  logic [4:0]           r_sel;
  logic                 r_busy, r_done, r_taken, r_illegal;
  logic [CNT_WIDTH-1:0] r_tcnt, r_ncnt;

  logic [4:0] w_opcode;
  logic       w_unused_ir;
  assign w_opcode    = ir[DATA_WIDTH-1 -: 5];
  assign w_unused_ir = ^ir[DATA_WIDTH-6:0];

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Strobe bit positions within r_str
  localparam int B_INCPC = 13, B_EPC = 12, B_EIR = 11, B_EY = 10, B_EZ = 9, B_EMAR = 8;
  localparam int B_EMDR = 7, B_RAMRD = 6, B_MDRRD = 5, B_GRA = 4, B_EROUT = 3, B_ERA = 2;
  localparam int B_ECON = 1, B_IMM = 0;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_str     <= '0;
      r_alu     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
      r_tcnt    <= '0;
      r_ncnt    <= '0;
    end else begin
      r_str  <= '0;
      r_alu  <= '0;
      r_sel  <= '0;
      r_done <= 1'b0;
      r_busy <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_busy <= start;
          if (start) begin
            r_state        <= S_F0;
            r_sel          <= SEL_PC;
            r_str[B_EMAR]  <= 1'b1;
            r_str[B_INCPC] <= 1'b1;
          end
        end
        S_F0: begin
          r_state        <= S_RD;
          r_wait         <= WAIT_INIT;
          r_str[B_RAMRD] <= 1'b1;
        end
        S_RD: begin
          if (r_wait == 4'd0) begin
            r_state        <= S_MDR;
            r_str[B_MDRRD] <= 1'b1;
            r_str[B_EMDR]  <= 1'b1;
          end else begin
            r_wait         <= r_wait - 4'd1;
            r_str[B_RAMRD] <= 1'b1;
          end
        end
        S_MDR: begin
          r_state      <= S_IR;
          r_sel        <= SEL_MDR;
          r_str[B_EIR] <= 1'b1;
        end
        S_IR: r_state <= S_DEC;
        // Opcode is only meaningful once IR has been loaded, so the decision is taken leaving DEC
        S_DEC: begin
          if (w_opcode == OP_BR) begin
            r_state        <= S_CON;
            r_illegal      <= 1'b0;
            r_sel          <= SEL_REG;
            r_str[B_GRA]   <= 1'b1;
            r_str[B_EROUT] <= 1'b1;
            r_str[B_ERA]   <= 1'b1;
            r_str[B_ECON]  <= 1'b1;
          end else begin
            r_state   <= S_DONE;
            r_illegal <= 1'b1;
            r_taken   <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        S_CON: begin
          r_state     <= S_PCY;
          r_sel       <= SEL_PC;
          r_str[B_EY] <= 1'b1;
        end
        S_PCY: begin
          r_state      <= S_ADD;
          r_alu        <= ALU_ADD;
          r_str[B_IMM] <= 1'b1;
          r_str[B_EZ]  <= 1'b1;
        end
        S_ADD: begin
          r_state      <= S_WB;
          r_sel        <= SEL_ZLO;
          r_str[B_EPC] <= con_ff;
        end
        S_WB: begin
          r_state <= S_DONE;
          r_taken <= con_ff;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!r_illegal) begin
            if (r_taken) r_tcnt <= sat_inc(r_tcnt);
            else         r_ncnt <= sat_inc(r_ncnt);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {incPC, e_PC, e_IR, e_Y, e_Z, e_MAR, e_MDR, ram_read, MDR_read,
          Gra, e_Rout, e_RA, e_CON_FF, imm_sel} = r_str;
  assign ALU_op        = r_alu;
  assign BusDataSelect = r_sel;
  assign busy          = r_busy;
  assign done          = r_done;
  assign taken         = r_taken;
  assign illegal       = r_illegal;
  assign taken_cnt     = r_tcnt;
  assign nottaken_cnt  = r_ncnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: two instances (MEM_WAIT=1/CNT_WIDTH=16 and MEM_WAIT=3/CNT_WIDTH=2)
// share stimulus; each is compared every cycle against a schedule-based model plus directed vectors.
module tb_branch_sequencer;

  localparam logic [4:0] OPBR = 5'b10010;
  localparam logic [4:0] SREG = 5'b00001, SZLO = 5'b10011, SPC = 5'b10100, SMDR = 5'b10101;
  localparam int P_IDLE = 0, P_F0 = 1, P_RD = 2, P_MDR = 3, P_IR = 4, P_DEC = 5;
  localparam int P_CON = 6, P_PCY = 7, P_ADD = 8, P_WB = 9, P_DONE = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear, start, con_ff;
  logic [31:0] ir;

  wire [13:0] a_str, b_str;
  wire [3:0]  a_alu, b_alu;
  wire [4:0]  a_sel, b_sel;
  wire        a_busy, a_done, a_taken, a_illegal, b_busy, b_done, b_taken, b_illegal;
  wire [15:0] a_tc, a_nc;
  wire [1:0]  b_tc, b_nc;

  branch_sequencer #(.DATA_WIDTH(32), .MEM_WAIT(1), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con_ff(con_ff),
    .incPC(a_str[13]), .e_PC(a_str[12]), .e_IR(a_str[11]), .e_Y(a_str[10]), .e_Z(a_str[9]),
    .e_MAR(a_str[8]), .e_MDR(a_str[7]), .ram_read(a_str[6]), .MDR_read(a_str[5]),
    .Gra(a_str[4]), .e_Rout(a_str[3]), .e_RA(a_str[2]), .e_CON_FF(a_str[1]), .imm_sel(a_str[0]),
    .ALU_op(a_alu), .BusDataSelect(a_sel), .busy(a_busy), .done(a_done), .taken(a_taken),
    .illegal(a_illegal), .taken_cnt(a_tc), .nottaken_cnt(a_nc));

  branch_sequencer #(.DATA_WIDTH(32), .MEM_WAIT(3), .CNT_WIDTH(2)) dut_b (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con_ff(con_ff),
    .incPC(b_str[13]), .e_PC(b_str[12]), .e_IR(b_str[11]), .e_Y(b_str[10]), .e_Z(b_str[9]),
    .e_MAR(b_str[8]), .e_MDR(b_str[7]), .ram_read(b_str[6]), .MDR_read(b_str[5]),
    .Gra(b_str[4]), .e_Rout(b_str[3]), .e_RA(b_str[2]), .e_CON_FF(b_str[1]), .imm_sel(b_str[0]),
    .ALU_op(b_alu), .BusDataSelect(b_sel), .busy(b_busy), .done(b_done), .taken(b_taken),
    .illegal(b_illegal), .taken_cnt(b_tc), .nottaken_cnt(b_nc));

  wire [58:0] act_a = {a_str, a_alu, a_sel, a_busy, a_done, a_taken, a_illegal, a_tc, a_nc};
  wire [58:0] act_b = {b_str, b_alu, b_sel, b_busy, b_done, b_taken, b_illegal, 14'd0, b_tc, 14'd0, b_nc};

  // Model: position within the instruction as a step count; phase follows from the schedule.
  typedef struct { bit act; int s; bit br; bit tk; bit il; bit epc; int tc; int nc; } mdl_t;
  mdl_t ma, mb;
  int n_tests = 0, n_fail = 0;

  function automatic int phase(mdl_t m, int mw);
    if (!m.act) return P_IDLE;
    if (m.s == 0) return P_F0;
    if (m.s <= mw) return P_RD;
    if (m.s == mw + 1) return P_MDR;
    if (m.s == mw + 2) return P_IR;
    if (m.s == mw + 3) return P_DEC;
    if (!m.br) return P_DONE;
    case (m.s - mw)
      4: return P_CON;
      5: return P_PCY;
      6: return P_ADD;
      7: return P_WB;
      default: return P_DONE;
    endcase
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit clr, bit st, logic [31:0] irv, bit con, int mw, int cw);
    mdl_t n;
    int mx;
    int ph;
    n = m;
    mx = (1 << cw) - 1;
    ph = phase(m, mw);
    if (clr) begin
      n = '{default: 0};
    end else if (!m.act) begin
      if (st) begin n.act = 1; n.s = 0; end
    end else begin
      n.s = m.s + 1;
      case (ph)
        P_DEC: begin
          n.br = (irv[31:27] == OPBR);
          if (n.br) n.il = 0;
          else begin n.il = 1; n.tk = 0; end
        end
        P_ADD: n.epc = con;
        P_WB:  n.tk = con;
        P_DONE: begin
          n.act = 0;
          if (m.br) begin
            if (m.tk) n.tc = (m.tc >= mx) ? mx : m.tc + 1;
            else      n.nc = (m.nc >= mx) ? mx : m.nc + 1;
          end
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [58:0] mexp(mdl_t m, int mw);
    logic [13:0] st;
    logic [3:0]  al;
    logic [4:0]  se;
    logic        dn;
    st = '0; al = '0; se = '0; dn = 1'b0;
    case (phase(m, mw))
      P_F0:   begin se = SPC; st[13] = 1; st[8] = 1; end
      P_RD:   st[6] = 1;
      P_MDR:  begin st[5] = 1; st[7] = 1; end
      P_IR:   begin se = SMDR; st[11] = 1; end
      P_CON:  begin se = SREG; st[4] = 1; st[3] = 1; st[2] = 1; st[1] = 1; end
      P_PCY:  begin se = SPC; st[10] = 1; end
      P_ADD:  begin al = 4'b0011; st[0] = 1; st[9] = 1; end
      P_WB:   begin se = SZLO; st[12] = m.epc; end
      P_DONE: dn = 1;
      default: ;
    endcase
    return {st, al, se, m.act, dn, m.tk, m.il, 16'(m.tc), 16'(m.nc)};
  endfunction

  function automatic logic [58:0] mmask(mdl_t m, int mw);
    logic [58:0] k;
    k = '1;
    if (m.act && phase(m, mw) != P_DONE) begin k[33] = 1'b0; k[32] = 1'b0; end
    return k;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    logic [58:0] k;
    @(posedge clock);
    ma = mstep(ma, clear, start, ir, con_ff, 1, 16);
    mb = mstep(mb, clear, start, ir, con_ff, 3, 2);
    #1;
    k = mmask(ma, 1);
    check("model_a", 64'(act_a & k), 64'(mexp(ma, 1) & k));
    k = mmask(mb, 3);
    check("model_b", 64'(act_b & k), 64'(mexp(mb, 3) & k));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < 60) begin tick(); n++; end
    check("idle_bound", 64'(n < 60), 64'd1);
  endtask

  task automatic run_instr(input logic [31:0] v_ir, input bit v_con,
                           output int cyc_a, output int cyc_b, output int rr_b,
                           output int ex_a, output bit tk_a, output bit il_a);
    int n;
    bit got_a, got_b;
    cyc_a = 0; cyc_b = 0; rr_b = 0; ex_a = 0; tk_a = 0; il_a = 0;
    got_a = 0; got_b = 0;
    ir = v_ir; con_ff = v_con; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!(got_a && got_b) && n < 60) begin
      tick();
      n++;
      if (b_str[6]) rr_b++;
      if (a_str[4] || a_str[10] || a_str[9] || a_str[0] || a_str[12] || a_sel == SZLO) ex_a++;
      if (a_done && !got_a) begin got_a = 1; cyc_a = n; tk_a = a_taken; il_a = a_illegal; end
      if (b_done && !got_b) begin got_b = 1; cyc_b = n; end
    end
    tick();
  endtask

  typedef struct {
    logic [31:0] ir; bit con; int lat_a; int lat_b; int ex; bit tk; bit il; int dtc; int dnc;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int ca, cb, rb, ex, t0, n0, n, cnt;
    bit tk, il, found;

    tbl[0] = '{32'h9100_0000, 1'b1, 10, 12, 4, 1'b1, 1'b0, 1, 0};
    tbl[1] = '{32'h9100_0000, 1'b0, 10, 12, 4, 1'b0, 1'b0, 0, 1};
    tbl[2] = '{32'h9188_0000, 1'b1, 10, 12, 4, 1'b1, 1'b0, 1, 0};
    tbl[3] = '{32'h4000_0000, 1'b1,  6,  8, 0, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{32'h9298_0000, 1'b0, 10, 12, 4, 1'b0, 1'b0, 0, 1};
    tbl[5] = '{32'hF800_0000, 1'b0,  6,  8, 0, 1'b0, 1'b1, 0, 0};

    ma = '{default: 0};
    mb = '{default: 0};
    clear = 1'b1; start = 1'b0; ir = '0; con_ff = 1'b0;
    tick();
    tick();
    check("reset_a", 64'(act_a), 64'd0);
    check("reset_b", 64'(act_b), 64'd0);
    clear = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      t0 = a_tc; n0 = a_nc;
      run_instr(tbl[i].ir, tbl[i].con, ca, cb, rb, ex, tk, il);
      check($sformatf("lat_a[%0d]", i), 64'(ca), 64'(tbl[i].lat_a));
      check($sformatf("lat_b[%0d]", i), 64'(cb), 64'(tbl[i].lat_b));
      check($sformatf("rdcyc_b[%0d]", i), 64'(rb), 64'd3);
      check($sformatf("exec_a[%0d]", i), 64'(ex), 64'(tbl[i].ex));
      check($sformatf("taken[%0d]", i), 64'(tk), 64'(tbl[i].tk));
      check($sformatf("illegal[%0d]", i), 64'(il), 64'(tbl[i].il));
      check($sformatf("dtaken[%0d]", i), 64'(int'(a_tc) - t0), 64'(tbl[i].dtc));
      check($sformatf("dnottaken[%0d]", i), 64'(int'(a_nc) - n0), 64'(tbl[i].dnc));
      wait_idle();
    end

    // clear during ADD aborts the instruction
    ir = 32'h9100_0000; con_ff = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 0; n = 0;
    while (!found && n < 20) begin tick(); n++; found = a_str[0]; end
    check("reach_add", 64'(found), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_abort_a", 64'(act_a), 64'd0);
    check("clear_abort_b", 64'(act_b), 64'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (a_done || b_done) cnt++; end
    check("no_done_after_clear", 64'(cnt), 64'd0);
    run_instr(32'h9100_0000, 1'b1, ca, cb, rb, ex, tk, il);
    check("post_clear_lat", 64'(ca), 64'd10);
    check("post_clear_cnt", 64'(a_tc), 64'd1);
    wait_idle();

    // start held high: back-to-back taken branches saturate the 2-bit counter
    ir = 32'h9100_0000; con_ff = 1'b1; start = 1'b1;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 300) begin tick(); n++; if (b_done) cnt++; end
    start = 1'b0;
    check("b2b_dones", 64'(cnt), 64'd5);
    wait_idle();
    check("sat_taken_b", 64'(b_tc), 64'd3);

    // a start pulse while busy must not launch a second instruction
    t0 = a_tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!a_done && n < 30) begin tick(); n++; end
    tick(); tick();
    check("busy_start_ignored", 64'(a_busy), 64'd0);
    check("busy_one_count", 64'(int'(a_tc) - t0), 64'd1);
    wait_idle();

    // randomized traffic, checked by the models every cycle
    for (int i = 0; i < 3000; i++) begin
      clear  = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 3) == 0);
      con_ff = $urandom_range(0, 1);
      ir     = {($urandom_range(0, 2) != 0) ? OPBR : 5'($urandom), 27'($urandom)};
      tick();
    end
    clear = 1'b0; start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
